// File: rtl/ram_bist_pkg.sv
// Shared types, state encodings and the address-dependent test pattern for ram_bist.
// The inverted-pass states exist only when RAM_BIST_INVERT_PASS_EN is defined.
package ram_bist_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_WRITE     = 3'd1;
    localparam state_t S_READ      = 3'd2;
    localparam state_t S_DONE      = 3'd3;
`ifdef RAM_BIST_INVERT_PASS_EN
    localparam state_t S_WRITE_INV = 3'd4;
    localparam state_t S_READ_INV  = 3'd5;
`endif

    function automatic logic [DEF_DATA_W-1:0] pat(
        input logic [DEF_DATA_W-1:0] seed,
        input logic [DEF_ADDR_W-1:0] addr,
        input logic [DEF_DATA_W-1:0] step,
        input logic                  inv
    );
        logic [DEF_DATA_W-1:0] p;
        p = seed + DEF_DATA_W'(addr) * step;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// Write/read port bundle between the BIST initiator (master) and the RAM under test (slave).
interface ram_bist_if import ram_bist_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] mem_in;
    logic              mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_out;

    modport master (output mem_in, output mem_load, output mem_address, input mem_out);
    modport slave  (input mem_in, input mem_load, input mem_address, output mem_out);
endinterface

// File: rtl/ram_bist_ctrl.sv
// Sequencer for ram_bist: FSM, address counter, write data and seed capture.
// Honours RAM_BIST_INVERT_PASS_EN by adding an inverted write/read pass.
module ram_bist_ctrl import ram_bist_pkg::*; #(
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] STEP   = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output state_t            state,
    output logic [ADDR_W-1:0] addr,
    output logic              load,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] seed_q,
    output logic              busy,
    output logic              done,
    output logic              launch,
    output logic              finish
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    logic last;

    assign last   = (addr == LAST);
    assign launch = start && ((state == S_IDLE) || (state == S_DONE));
`ifdef RAM_BIST_INVERT_PASS_EN
    assign finish = (state == S_READ_INV) && last;
`else
    assign finish = (state == S_READ) && last;
`endif

    // The last address of every pass is terminal, so the counter never wraps mid-pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            addr   <= '0;
            load   <= 1'b0;
            wdata  <= '0;
            seed_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (launch) begin
            state  <= S_WRITE;
            addr   <= '0;
            load   <= 1'b1;
            wdata  <= pat(seed, '0, STEP, 1'b0);
            seed_q <= seed;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else begin
            case (state)
                S_WRITE: begin
                    if (last) begin
                        state <= S_READ;
                        addr  <= '0;
                        load  <= 1'b0;
                        wdata <= '0;
                    end else begin
                        addr  <= addr + 1'b1;
                        wdata <= pat(seed_q, addr + 1'b1, STEP, 1'b0);
                    end
                end
                S_READ: begin
                    if (last) begin
                        addr <= '0;
`ifdef RAM_BIST_INVERT_PASS_EN
                        state <= S_WRITE_INV;
                        load  <= 1'b1;
                        wdata <= pat(seed_q, '0, STEP, 1'b1);
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
`ifdef RAM_BIST_INVERT_PASS_EN
                S_WRITE_INV: begin
                    if (last) begin
                        state <= S_READ_INV;
                        addr  <= '0;
                        load  <= 1'b0;
                        wdata <= '0;
                    end else begin
                        addr  <= addr + 1'b1;
                        wdata <= pat(seed_q, addr + 1'b1, STEP, 1'b1);
                    end
                end
                S_READ_INV: begin
                    if (last) begin
                        state <= S_DONE;
                        addr  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_bist.sv
// RAM built-in self-test: writes a seeded pattern, reads it back, reports errors and first failure.
// Define RAM_BIST_INVERT_PASS_EN to append a second pass using the inverted pattern.
module ram_bist import ram_bist_pkg::*; #(
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] STEP   = DATA_W'(1),
    parameter int                ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    ram_bist_if.master        mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] seed_q;
    logic              load;
    logic              launch;
    logic              finish;
    logic              compare_en;
    logic              inv_pass;
    logic              mismatch;
    logic [DATA_W-1:0] expected;
    logic [ERR_W-1:0]  err_next;

    ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STEP(STEP)) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .seed   (seed),
        .state  (state),
        .addr   (addr),
        .load   (load),
        .wdata  (wdata),
        .seed_q (seed_q),
        .busy   (busy),
        .done   (done),
        .launch (launch),
        .finish (finish)
    );

    assign mem.mem_in      = wdata;
    assign mem.mem_load    = load;
    assign mem.mem_address = addr;

`ifdef RAM_BIST_INVERT_PASS_EN
    assign inv_pass   = (state == S_READ_INV);
    assign compare_en = (state == S_READ) || inv_pass;
`else
    assign inv_pass   = 1'b0;
    assign compare_en = (state == S_READ);
`endif

    assign expected = pat(seed_q, addr, STEP, inv_pass);
    assign mismatch = compare_en && (mem.mem_out != expected);
    assign err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

    // Verdict uses err_next so the final compare of the run is included in pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
        end else if (launch) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
        end else begin
            if (mismatch) begin
                err_count <= err_next;
                if (err_count == '0) begin
                    fail_addr <= addr;
                    fail_data <= mem.mem_out;
                end
            end
            if (finish) begin
                pass <= (err_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a behavioural 64-word RAM and a second, ERR_W=4 instance tied to zero.
// Expectations follow RAM_BIST_INVERT_PASS_EN when it is defined.
module tb_ram_bist;
    import ram_bist_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;
`ifdef RAM_BIST_INVERT_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int LAT = 2 * DEPTH * NPASS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, pass;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          busy4, done4, pass4;
    logic [3:0]    err4;
    logic [AW-1:0] fail_addr4;
    logic [DW-1:0] fail_data4;

    logic [DW-1:0] ram [DEPTH];
    logic          tieZero = 1'b0;
    logic          injectFault = 1'b0;
    logic          sawAddr9 = 1'b0;
    logic [DW-1:0] addr9Data = '0;
    int            checks = 0;
    int            passes = 0;
    int            fails = 0;
    int            edges;
    int            busyCycles;
    logic          reached;

    ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();
    ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem4 ();

    ram_bist dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .mem       (mem),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    ram_bist #(.ERR_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .mem       (mem4),
        .busy      (busy4),
        .done      (done4),
        .pass      (pass4),
        .err_count (err4),
        .fail_addr (fail_addr4),
        .fail_data (fail_data4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem.mem_load) ram[mem.mem_address] <= mem.mem_in;
    end

    assign mem.mem_out  = tieZero ? '0 :
                          (ram[mem.mem_address] ^ {{(DW-1){1'b0}}, (injectFault && (mem.mem_address == 6'h12))});
    assign mem4.mem_out = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Launches a run at the next edge and counts edges until done rises (bounded).
    task automatic applyStimulus(input logic [DW-1:0] s, input bit holdStart,
                                 output int nEdges, output int nBusy);
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        if (!holdStart) start = 1'b0;
        nEdges = 0;
        nBusy  = busy ? 1 : 0;
        while (!done && nEdges < 4 * LAT) begin
            @(posedge clk); #1;
            nEdges++;
            if (busy) nBusy++;
            if (mem.mem_load && mem.mem_address == 6'd9 && !sawAddr9) begin
                addr9Data = mem.mem_in;
                sawAddr9  = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;

        #2;
        checkOutput("reset_status", {busy, done, pass, err_count}, 32'h0);
        checkOutput("reset_fail", {fail_addr, fail_data}, 32'h0);
        checkOutput("reset_port", {mem.mem_load, mem.mem_address, mem.mem_in}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: seed 0, clean RAM
        applyStimulus(16'h0000, 1'b0, edges, busyCycles);
        checkOutput("t1_latency", edges, LAT);
        checkOutput("t1_busy_cycles", busyCycles, LAT);
        checkOutput("t1_done_busy", {done, busy}, 32'h2);
        checkOutput("t1_pass", pass, 1);
        checkOutput("t1_err", err_count, 0);

        // 2: seed 0x8285, pattern spot checks
        sawAddr9 = 1'b0;
        applyStimulus(16'h8285, 1'b0, edges, busyCycles);
        checkOutput("t2_latency", edges, LAT);
        checkOutput("t2_addr9_data", {sawAddr9, addr9Data}, {16'd1, 16'h828E});
`ifdef RAM_BIST_INVERT_PASS_EN
        checkOutput("t2_ram63", ram[63], 16'h7D3B);
`else
        checkOutput("t2_ram63", ram[63], 16'h82C4);
`endif
        checkOutput("t2_pass", pass, 1);

        // 3: single-bit fault at address 0x12
        injectFault = 1'b1;
        applyStimulus(16'h1000, 1'b0, edges, busyCycles);
        injectFault = 1'b0;
        checkOutput("t3_err", err_count, NPASS);
        checkOutput("t3_fail_addr", fail_addr, 6'h12);
        checkOutput("t3_fail_data", fail_data, 16'h1013);
        checkOutput("t3_pass", pass, 0);
        checkOutput("t3_done", done, 1);

        // 4: read data stuck at zero; second instance saturates at 4 bits
        tieZero = 1'b1;
        applyStimulus(16'h0001, 1'b0, edges, busyCycles);
        tieZero = 1'b0;
        checkOutput("t4_err", err_count, 64 * NPASS);
        checkOutput("t4_fail_addr", fail_addr, 0);
        checkOutput("t4_fail_data", fail_data, 0);
        checkOutput("t4_pass", pass, 0);
        checkOutput("t4_err_sat", {done4, err4}, 32'h1F);
        checkOutput("t4_pass_sat", pass4, 0);

        // 5: reset during WRITE at address 20, then restart
        seed  = 16'h4321;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (mem.mem_load && mem.mem_address == 6'd20) reached = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checkOutput("t5_reached_addr20", reached, 1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_status", {busy, done, pass, err_count}, 32'h0);
        checkOutput("t5_rst_fail", {fail_addr, fail_data}, 32'h0);
        checkOutput("t5_rst_port", {mem.mem_load, mem.mem_address, mem.mem_in}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(16'h4321, 1'b0, edges, busyCycles);
        checkOutput("t5_latency", edges, LAT);
        checkOutput("t5_pass", pass, 1);

        // 6: start held high throughout
        applyStimulus(16'h5A5A, 1'b1, edges, busyCycles);
        checkOutput("t6_latency", edges, LAT);
        checkOutput("t6_busy_cycles", busyCycles, LAT);
`ifdef RAM_BIST_INVERT_PASS_EN
        checkOutput("t6_ram0", ram[0], 16'hA5A5);
`else
        checkOutput("t6_ram0", ram[0], 16'h5A5A);
`endif
        @(posedge clk); #1;
        checkOutput("t6_relaunch", {busy, done, mem.mem_load, mem.mem_address}, {29'd0, 3'b101} << 6);
        start = 1'b0;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test initiator for the 64-word RAM block.
- Drives the RAM's write port (data in, load, address) and reads back its combinational output.
- Writes a seeded address-dependent pattern to every word, then reads each word back and checks it.
- Reports pass/fail, error count and first failing location; used in bring-up and for regression of the RAM hierarchy.

Parameters:
ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W words
DATA_W, 16, RAM word width
STEP, 16'h0001, pattern increment per address
ERR_W, 8, error counter width (saturating)

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  launch request, sampled in IDLE/DONE only
seed_i  in  DATA_W  pattern seed, captured on accepted start
mem_in_o  out  DATA_W  to RAM in_i
mem_load_o  out  1  to RAM load_i
mem_address_o  out  ADDR_W  to RAM address_i
mem_out_i  in  DATA_W  from RAM out_o (combinational of address)
busy_o  out  1  test in progress
done_o  out  1  level; test finished
pass_o  out  1  valid when done_o; 1 iff err_count_o == 0
err_count_o  out  ERR_W  mismatches, saturates at all-ones
fail_addr_o  out  ADDR_W  address of first mismatch
fail_data_o  out  DATA_W  data read at first mismatch

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0, including mem_load_o=0 and mem_address_o=0.
- Pattern: pat(a) = seed + a*STEP, mod 2^DATA_W. In the inverted pass the word is ~pat(a).
- States: IDLE, WRITE, READ, DONE. All outputs are registered.
- Start, in IDLE or DONE: start_i=1 at an edge accepts the start.
  - Seed is captured.
  - err_count, fail_addr and fail_data clear; done_o and pass_o clear; busy_o sets.
  - State goes to WRITE with address 0, load 1, data pat(0).
- WRITE: each edge increments the address and updates the data.
  - At the edge that commits address DEPTH-1, go to READ: address 0, load 0, mem_in_o=0.
- READ: at each edge, compare mem_in_i… i.e. compare mem_out_i against the expected word for the current address.
  - On mismatch, err_count increments (saturating at all-ones).
  - If this is the first mismatch, capture the address into fail_addr and mem_out_i into fail_data.
  - The address then increments.
  - After address DEPTH-1 is compared, go to DONE: busy 0, done 1, pass = (count==0 including this compare).
- Latency: done_o rises exactly 2*DEPTH edges after the start edge (128 at defaults).
- start_i while busy is ignored. done_o holds in DONE until a new start is accepted or reset.
- Address wrap: the counter never wraps mid-pass. DEPTH-1 is terminal for each pass.
- Reset mid-operation: aborts immediately. RAM contents are left partial; no recovery is needed.

Optional Feature:
- Macro: RAM_BIST_INVERT_PASS_EN.
- When defined: after the first READ pass, run a second WRITE and READ pass with ~pat(a). Error accounting is shared across both passes; first-fail capture covers both passes.
  - States gain WRITE_INV and READ_INV.
  - done_o rises 4*DEPTH edges after start (256).
- When undefined: single pass only; those states do not exist.

Decomposition:
- Package ram_bist_pkg holds:
  - the state enum;
  - ADDR_W and DATA_W defaults;
  - the pattern function pat(seed, addr, step, inv).
- One sub-module is natural: ram_bist_ctrl, containing the FSM and address counter.
- The top level holds the compare, error counter and capture registers, and instantiates the controller.

Test Plan:
1. Reset; seed 0x0000; real RAM64 attached -> done_o=1 exactly 128 edges after the start edge; pass_o=1; err_count_o=0; busy_o high for 128 cycles.
2. Seed 0x8285 -> during WRITE, address 9 carries 0x828E; after done, the RAM word at address 63 = 0x82C4; pass_o=1.
3. Bench XORs bit 0 into mem_out_i when address=0x12 -> err_count_o=1, fail_addr_o=0x12, fail_data_o = pat(0x12)^1, pass_o=0.
4. mem_out_i tied to 0 with seed 0x0001 -> err_count_o=64, fail_addr_o=0; with ERR_W=4 -> err_count_o=15 (saturated).
5. Assert rst_i while in WRITE at address 20 -> all outputs 0 at once; a restart then completes in 128 edges with pass_o=1.
6. start_i held high throughout -> the run is not restarted while busy; relaunch occurs on the edge after done_o rises; with RAM_BIST_INVERT_PASS_EN, done_o arrives after 256 edges and word 0 reads ~seed.
